// File: rtl/sigmoid_pkg.sv
// Shared types and constants for the sigmoid accelerator output stream stage.
package sigmoid_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN_A   = 3'd1,
    DRAIN_A = 3'd2,
    DONE_A  = 3'd3,
    RUN_B   = 3'd4,
    DRAIN_B = 3'd5,
    DONE_B  = 3'd6
  } stream_states;

  // Default half size; the top module can override it through its own parameter.
  localparam int SIG_HALF_BYTES = 2048;
  localparam int HALF_A_BASE    = 0;
  localparam int HALF_B_BASE    = SIG_HALF_BYTES;

  localparam int STAT_A = 0;
  localparam int STAT_B = 1;

endpackage

// File: rtl/sigmoid_stream_out_if.sv
// BRAM read port plus AXI4-Stream master bundle for the sigmoid output stage.
interface sigmoid_stream_out_if #(
  parameter int BRAM_WIDTH = 32,
  parameter int WORD_BYTES = 4,
  parameter int ADDR_WIDTH = 12
);

  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [BRAM_WIDTH-1:0] bram_rddata;
  logic [BRAM_WIDTH-1:0] bram_wrdata;
  logic [WORD_BYTES-1:0] bram_we;

  logic [BRAM_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport master (
    output bram_addr,
    output bram_wrdata,
    output bram_we,
    input  bram_rddata,
    output m_axis_tdata,
    output m_axis_tvalid,
    output m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  bram_addr,
    input  bram_wrdata,
    input  bram_we,
    output bram_rddata,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    output m_axis_tready
  );

endinterface

// File: rtl/sigmoid_stream_out_skid_fifo.sv
// Small power-of-two FIFO absorbing BRAM read latency ahead of the AXI4-Stream output.
module stream_skid_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the same cycle frees a slot.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/sigmoid_stream_out.sv
// Streams one ping-pong half of the sigmoid output BRAM over AXI4-Stream per ps_control request.
module sigmoid_stream_out
  import sigmoid_pkg::*;
#(
  parameter int BRAM_WIDTH = 32,
  parameter int WORD_BYTES = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int HALF_BYTES = SIG_HALF_BYTES,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         ps_control,
  output logic [31:0]         pl_status,
  sigmoid_stream_out_if.master bus
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CRW = CW + 1;

  localparam logic [ADDR_WIDTH-1:0] A_BASE = ADDR_WIDTH'(HALF_A_BASE);
  localparam logic [ADDR_WIDTH-1:0] B_BASE = ADDR_WIDTH'(HALF_A_BASE + HALF_BYTES);
  localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(HALF_A_BASE + HALF_BYTES - WORD_BYTES);
  localparam logic [ADDR_WIDTH-1:0] B_LAST = ADDR_WIDTH'(HALF_A_BASE + 2 * HALF_BYTES - WORD_BYTES);
  localparam logic [ADDR_WIDTH-1:0] STEP   = ADDR_WIDTH'(WORD_BYTES);

  stream_states state;
  stream_states next_state;

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  done_a;
  logic                  done_b;
  logic                  inflight;
  logic                  inflight_last;

  logic                  start_a;
  logic                  start_b;
  logic                  issue;
  logic                  issue_last;
  logic                  load_a;
  logic                  load_b;
  logic                  set_a;
  logic                  set_b;
  logic                  pop;
  logic                  credit_ok;
  logic [CRW-1:0]        credit_used;

  logic [BRAM_WIDTH:0]   fifo_out;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic                  unused_ctrl;

  assign unused_ctrl = ^ps_control[31:2];

  assign start_a = ps_control[STAT_A] && !done_a;
  assign start_b = ps_control[STAT_B] && !done_b;
  assign pop     = bus.m_axis_tvalid && bus.m_axis_tready;

  // Credits count words already buffered plus the one in BRAM flight, net of this cycle's pop.
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign credit_ok   = credit_used < CRW'(FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_a)      next_state = RUN_A;
        else if (start_b) next_state = RUN_B;
      end
      RUN_A:   if (issue_last) next_state = DRAIN_A;
      DRAIN_A: if (fifo_empty && !inflight) next_state = DONE_A;
      DONE_A:  next_state = IDLE;
      RUN_B:   if (issue_last) next_state = DRAIN_B;
      DRAIN_B: if (fifo_empty && !inflight) next_state = DONE_B;
      DONE_B:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    issue      = 1'b0;
    issue_last = 1'b0;
    load_a     = 1'b0;
    load_b     = 1'b0;
    set_a      = 1'b0;
    set_b      = 1'b0;
    case (state)
      IDLE: begin
        load_a = start_a;
        load_b = !start_a && start_b;
      end
      RUN_A: begin
        issue      = credit_ok;
        issue_last = credit_ok && (rd_addr == A_LAST);
      end
      RUN_B: begin
        issue      = credit_ok;
        issue_last = credit_ok && (rd_addr == B_LAST);
      end
      DONE_A:  set_a = 1'b1;
      DONE_B:  set_b = 1'b1;
      default: ;
    endcase
  end

  // The address parks on the final word instead of stepping past it, so half B never wraps.
  always_ff @(posedge clk) begin
    if (!reset)                  rd_addr <= '0;
    else if (load_a)             rd_addr <= A_BASE;
    else if (load_b)             rd_addr <= B_BASE;
    else if (issue && !issue_last) rd_addr <= rd_addr + STEP;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      done_a <= 1'b0;
      done_b <= 1'b0;
    end else begin
      if (set_a)                        done_a <= 1'b1;
      else if (!ps_control[STAT_A])     done_a <= 1'b0;
      if (set_b)                        done_b <= 1'b1;
      else if (!ps_control[STAT_B])     done_b <= 1'b0;
    end
  end

  stream_skid_fifo #(
    .WIDTH (BRAM_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data ({inflight_last, bus.bram_rddata}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign bus.m_axis_tvalid = !fifo_empty;
  assign bus.m_axis_tdata  = fifo_out[BRAM_WIDTH-1:0];
  assign bus.m_axis_tlast  = fifo_out[BRAM_WIDTH] && !fifo_empty;

  assign bus.bram_addr   = rd_addr;
  assign bus.bram_wrdata = '0;
  assign bus.bram_we     = '0;

  always_comb begin
    pl_status         = '0;
    pl_status[STAT_A] = done_a;
    pl_status[STAT_B] = done_b;
  end

endmodule

// File: tb/tb_sigmoid_stream_out.sv
// Self-checking bench: BRAM model plus a per-half expected-word model driven with random tready.
module tb_sigmoid_stream_out;

  localparam int WORDS = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ps_control;
  logic [31:0] pl_status;

  sigmoid_stream_out_if #(.BRAM_WIDTH(32), .WORD_BYTES(4), .ADDR_WIDTH(12)) bus_if ();

  sigmoid_stream_out #(
    .BRAM_WIDTH (32),
    .WORD_BYTES (4),
    .ADDR_WIDTH (12),
    .HALF_BYTES (2048),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps_control (ps_control),
    .pl_status  (pl_status),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  logic [31:0] bram_mem [1024];

  always @(posedge clk) bus_if.bram_rddata <= bram_mem[bus_if.bram_addr[11:2]];

  int          vectors;
  int          miscompares;
  logic [31:0] got_data[$];
  logic        got_last[$];
  int          got_cyc[$];
  logic [31:0] got_stat[$];
  int          hold_errs;
  logic [11:0] max_addr;
  bit          timed_out;

  // Word idx of half h lives at byte address h*2048 + 4*idx.
  function automatic logic [31:0] exp_word(input int half, input int idx);
    return bram_mem[half * WORDS + idx];
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < 1024; i++) bram_mem[i] = 32'h3f000000 + i;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) bram_mem[i] = $urandom;
  endtask

  // Drives tready at each falling edge and records every handshaked beat.
  task automatic collect_beats(input int ready_pct, input int max_beats, input int limit);
    logic [31:0] prev_data;
    logic        prev_last;
    bit          prev_stall;
    bit          rdy;
    int          cyc;
    got_data.delete(); got_last.delete(); got_cyc.delete(); got_stat.delete();
    hold_errs = 0; max_addr = '0; timed_out = 0;
    prev_stall = 0; prev_data = '0; prev_last = 1'b0; cyc = 0;
    while (got_data.size() < max_beats) begin
      @(negedge clk);
      cyc++;
      if (cyc > limit) begin
        timed_out = 1;
        break;
      end
      if (prev_stall && (bus_if.m_axis_tvalid !== 1'b1 || bus_if.m_axis_tdata !== prev_data ||
                         bus_if.m_axis_tlast !== prev_last))
        hold_errs++;
      if (bus_if.bram_addr > max_addr) max_addr = bus_if.bram_addr;
      rdy = ($urandom_range(0, 99) < ready_pct);
      bus_if.m_axis_tready = rdy;
      if (bus_if.m_axis_tvalid === 1'b1 && rdy) begin
        got_data.push_back(bus_if.m_axis_tdata);
        got_last.push_back(bus_if.m_axis_tlast);
        got_cyc.push_back(cyc);
        got_stat.push_back(pl_status);
      end
      prev_stall = (bus_if.m_axis_tvalid === 1'b1) && !rdy;
      prev_data  = bus_if.m_axis_tdata;
      prev_last  = bus_if.m_axis_tlast;
    end
  endtask

  task automatic wait_status(input logic [31:0] exp, input int limit, output bit ok);
    ok = 0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (pl_status === exp) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ps_control = '0;
    bus_if.m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus_if.m_axis_tvalid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_tvalid: got %b expected 0", bus_if.m_axis_tvalid);
    end
    vectors++;
    if (bus_if.m_axis_tlast !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_tlast: got %b expected 0", bus_if.m_axis_tlast);
    end
    vectors++;
    if (pl_status !== 32'h0) begin
      miscompares++; $display("[TB] FAIL reset_status: got %h expected 0", pl_status);
    end
    vectors++;
    if (bus_if.bram_addr !== 12'h0) begin
      miscompares++; $display("[TB] FAIL reset_addr: got %0d expected 0", bus_if.bram_addr);
    end
    vectors++;
    if (bus_if.bram_we !== 4'h0 || bus_if.bram_wrdata !== 32'h0) begin
      miscompares++; $display("[TB] FAIL reset_write_port: got we=%h wd=%h expected 0", bus_if.bram_we, bus_if.bram_wrdata);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus_if.m_axis_tvalid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL idle_tvalid: got %b expected 0", bus_if.m_axis_tvalid);
    end
  endtask

  task automatic test_full_speed();
    bit ok;
    int first;
    fill_ramp();
    ps_control = 32'h1;
    bus_if.m_axis_tready = 1'b1;
    collect_beats(100, WORDS, 3000);
    vectors++;
    if (timed_out || got_data.size() != WORDS) begin
      miscompares++; $display("[TB] FAIL full_count: got %0d beats expected %0d", got_data.size(), WORDS);
    end
    first = (got_cyc.size() > 0) ? got_cyc[0] : -1;
    vectors++;
    if (first != 3) begin
      miscompares++; $display("[TB] FAIL full_latency: got cycle %0d expected 3", first);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== exp_word(0, i)) begin
        miscompares++; $display("[TB] FAIL full_data[%0d]: got %h expected %h", i, got_data[i], exp_word(0, i));
      end
      vectors++;
      if (got_last[i] !== (i == WORDS - 1)) begin
        miscompares++; $display("[TB] FAIL full_tlast[%0d]: got %b expected %b", i, got_last[i], (i == WORDS - 1));
      end
      vectors++;
      if (got_cyc[i] != first + i) begin
        miscompares++; $display("[TB] FAIL full_no_bubble[%0d]: got cycle %0d expected %0d", i, got_cyc[i], first + i);
      end
    end
    vectors++;
    if (max_addr !== 12'd2044) begin
      miscompares++; $display("[TB] FAIL full_max_addr: got %0d expected 2044", max_addr);
    end
    wait_status(32'h1, 10, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("[TB] FAIL full_status_set: got %h expected 1", pl_status);
    end
  endtask

  task automatic test_flag_ack();
    bit ok;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++;
      if (bus_if.m_axis_tvalid !== 1'b0 || pl_status !== 32'h1) begin
        miscompares++; $display("[TB] FAIL no_restart[%0d]: got tvalid=%b status=%h expected 0/1", c, bus_if.m_axis_tvalid, pl_status);
      end
    end
    ps_control = 32'h0;
    @(negedge clk);
    vectors++;
    if (pl_status !== 32'h0) begin
      miscompares++; $display("[TB] FAIL ack_clear: got %h expected 0", pl_status);
    end
    ps_control = 32'h1;
    collect_beats(100, WORDS, 3000);
    vectors++;
    if (timed_out || got_data.size() != WORDS) begin
      miscompares++; $display("[TB] FAIL resend_count: got %0d beats expected %0d", got_data.size(), WORDS);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== exp_word(0, i) || got_last[i] !== (i == WORDS - 1)) begin
        miscompares++; $display("[TB] FAIL resend_beat[%0d]: got %h/%b expected %h/%b", i, got_data[i], got_last[i], exp_word(0, i), (i == WORDS - 1));
      end
    end
    wait_status(32'h1, 10, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("[TB] FAIL resend_status: got %h expected 1", pl_status);
    end
    ps_control = 32'h0;
    wait_status(32'h0, 3, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("[TB] FAIL resend_clear: got %h expected 0", pl_status);
    end
  endtask

  task automatic test_random_ready();
    bit ok;
    ps_control = 32'h1;
    collect_beats(30, WORDS, 8000);
    vectors++;
    if (timed_out || got_data.size() != WORDS) begin
      miscompares++; $display("[TB] FAIL rand_count: got %0d beats expected %0d", got_data.size(), WORDS);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== exp_word(0, i) || got_last[i] !== (i == WORDS - 1)) begin
        miscompares++; $display("[TB] FAIL rand_beat[%0d]: got %h/%b expected %h/%b", i, got_data[i], got_last[i], exp_word(0, i), (i == WORDS - 1));
      end
    end
    vectors++;
    if (hold_errs != 0) begin
      miscompares++; $display("[TB] FAIL rand_hold: got %0d unstable stalls expected 0", hold_errs);
    end
    vectors++;
    if (max_addr !== 12'd2044) begin
      miscompares++; $display("[TB] FAIL rand_max_addr: got %0d expected 2044", max_addr);
    end
    wait_status(32'h1, 10, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("[TB] FAIL rand_status: got %h expected 1", pl_status);
    end
    ps_control = 32'h0;
    wait_status(32'h0, 3, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("[TB] FAIL rand_clear: got %h expected 0", pl_status);
    end
  endtask

  task automatic test_both_halves();
    bit          ok;
    logic [31:0] exp_d;
    bit          exp_l;
    fill_random();
    ps_control = 32'h3;
    collect_beats(70, 2 * WORDS, 6000);
    vectors++;
    if (timed_out || got_data.size() != 2 * WORDS) begin
      miscompares++; $display("[TB] FAIL both_count: got %0d beats expected %0d", got_data.size(), 2 * WORDS);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      exp_d = (i < WORDS) ? exp_word(0, i) : exp_word(1, i - WORDS);
      exp_l = (i == WORDS - 1) || (i == 2 * WORDS - 1);
      vectors++;
      if (got_data[i] !== exp_d || got_last[i] !== exp_l) begin
        miscompares++; $display("[TB] FAIL both_beat[%0d]: got %h/%b expected %h/%b", i, got_data[i], got_last[i], exp_d, exp_l);
      end
    end
    if (got_stat.size() > 600) begin
      vectors++;
      if (got_stat[0] !== 32'h0 || got_stat[600] !== 32'h1) begin
        miscompares++; $display("[TB] FAIL both_status_a: got %h,%h expected 0,1", got_stat[0], got_stat[600]);
      end
    end
    vectors++;
    if (max_addr !== 12'd4092) begin
      miscompares++; $display("[TB] FAIL both_max_addr: got %0d expected 4092", max_addr);
    end
    wait_status(32'h3, 10, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("[TB] FAIL both_status: got %h expected 3", pl_status);
    end
    ps_control = 32'h0;
    wait_status(32'h0, 3, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("[TB] FAIL both_clear: got %h expected 0", pl_status);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int first;
    ps_control = 32'h1;
    collect_beats(100, 100, 1000);
    vectors++;
    if (timed_out) begin
      miscompares++; $display("[TB] FAIL mid_prefix: got %0d beats expected 100", got_data.size());
    end
    reset = 1'b0;
    bus_if.m_axis_tready = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus_if.m_axis_tvalid !== 1'b0 || pl_status !== 32'h0 || bus_if.bram_addr !== 12'h0) begin
      miscompares++; $display("[TB] FAIL mid_reset: got tvalid=%b status=%h addr=%0d expected 0/0/0", bus_if.m_axis_tvalid, pl_status, bus_if.bram_addr);
    end
    reset = 1'b1;
    collect_beats(100, WORDS, 3000);
    vectors++;
    if (timed_out || got_data.size() != WORDS) begin
      miscompares++; $display("[TB] FAIL mid_count: got %0d beats expected %0d", got_data.size(), WORDS);
    end
    first = (got_cyc.size() > 0) ? got_cyc[0] : -1;
    vectors++;
    if (first != 3) begin
      miscompares++; $display("[TB] FAIL mid_latency: got cycle %0d expected 3", first);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== exp_word(0, i) || got_last[i] !== (i == WORDS - 1)) begin
        miscompares++; $display("[TB] FAIL mid_beat[%0d]: got %h/%b expected %h/%b", i, got_data[i], got_last[i], exp_word(0, i), (i == WORDS - 1));
      end
    end
    wait_status(32'h1, 10, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("[TB] FAIL mid_status: got %h expected 1", pl_status);
    end
    ps_control = 32'h0;
    wait_status(32'h0, 3, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("[TB] FAIL mid_clear: got %h expected 0", pl_status);
    end
  endtask

  task automatic test_stall();
    bit ok;
    fill_ramp();
    ps_control = 32'h1;
    bus_if.m_axis_tready = 1'b1;
    collect_beats(100, 1, 100);
    vectors++;
    if (got_data.size() != 1 || got_data[0] !== exp_word(0, 0)) begin
      miscompares++; $display("[TB] FAIL stall_first: got %0d beats expected word %h", got_data.size(), exp_word(0, 0));
    end
    // One word popped plus a full FIFO means five reads issued, so the address parks at 5 words.
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      bus_if.m_axis_tready = 1'b0;
      vectors++;
      if (bus_if.m_axis_tvalid !== 1'b1 || bus_if.m_axis_tdata !== exp_word(0, 1)) begin
        miscompares++; $display("[TB] FAIL stall_hold[%0d]: got %b/%h expected 1/%h", c, bus_if.m_axis_tvalid, bus_if.m_axis_tdata, exp_word(0, 1));
      end
      if (c >= 10) begin
        vectors++;
        if (bus_if.bram_addr !== 12'd20) begin
          miscompares++; $display("[TB] FAIL stall_addr[%0d]: got %0d expected 20", c, bus_if.bram_addr);
        end
      end
    end
    collect_beats(100, WORDS - 1, 3000);
    vectors++;
    if (timed_out || got_data.size() != WORDS - 1) begin
      miscompares++; $display("[TB] FAIL stall_count: got %0d beats expected %0d", got_data.size(), WORDS - 1);
    end
    for (int i = 0; i < got_data.size(); i++) begin
      vectors++;
      if (got_data[i] !== exp_word(0, i + 1) || got_last[i] !== (i == WORDS - 2)) begin
        miscompares++; $display("[TB] FAIL stall_beat[%0d]: got %h/%b expected %h/%b", i, got_data[i], got_last[i], exp_word(0, i + 1), (i == WORDS - 2));
      end
    end
    wait_status(32'h1, 10, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("[TB] FAIL stall_status: got %h expected 1", pl_status);
    end
    ps_control = 32'h0;
    wait_status(32'h0, 3, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("[TB] FAIL stall_clear: got %h expected 0", pl_status);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    ps_control = '0;
    bus_if.m_axis_tready = 1'b0;
    fill_ramp();
    @(negedge clk);
    test_reset();
    test_full_speed();
    test_flag_ack();
    test_random_ready();
    test_both_halves();
    test_reset_mid();
    test_stall();
    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sigmoid_stream_out.md
Name: sigmoid_stream_out

Overview:
- Downstream stage of the sigmoid accelerator. Reads the sigmoid output BRAM one ping-pong half at a time and streams the fp32 results over AXI4-Stream to the DMA.
- Uses the same ps_control/pl_status half-buffer handshake as the sigmoid engine. Software can therefore drain half A while the engine fills half B, and vice versa.

Parameters:
- BRAM_WIDTH, 32, data word width (fp32).
- WORD_BYTES, 4, bytes per word; also the address step.
- ADDR_WIDTH, 12, BRAM byte-address width.
- HALF_BYTES, 2048, byte size of one half; half A starts at 0, half B at HALF_BYTES.
- FIFO_DEPTH, 4, output skid FIFO entries (power of two, minimum 2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- ps_control  in  32  bit0 = start/ack half A, bit1 = start/ack half B; other bits ignored.
- pl_status  out  32  bit0 = half A sent, bit1 = half B sent; other bits 0.
- bram_addr  out  ADDR_WIDTH  BRAM byte address.
- bram_rddata  in  BRAM_WIDTH  BRAM read data, valid exactly 1 cycle after the address.
- bram_wrdata  out  BRAM_WIDTH  tied 0.
- bram_we  out  WORD_BYTES  tied 0.
- m_axis_tdata  out  BRAM_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  high on the final word of a half.

Behaviour:
Reset:
- Reset (reset==0 at a clk edge) is synchronous and active-low.
- Reset value of every output: state IDLE, FIFO empty, m_axis_tvalid 0, m_axis_tlast 0, pl_status 0, bram_addr 0, read counter and in-flight flag cleared.
- Reset mid-transfer discards all buffered and in-flight words with no further beats.

State machine:
- States: IDLE, RUN_A, DRAIN_A, DONE_A, RUN_B, DRAIN_B, DONE_B.
- IDLE → RUN_A if ps_control[0] && !doneA_flag; else → RUN_B if ps_control[1] && !doneB_flag; else stay. A has priority when both bits are set.
- RUN_x: on entry the read address is the half base.
  - A read issues when (fifo_count + inflight − pop) < FIFO_DEPTH; the address advances by WORD_BYTES per issued read.
  - After the read of base+HALF_BYTES−WORD_BYTES issues, → DRAIN_x.
- DRAIN_x: → DONE_x once the FIFO is empty, nothing is in flight, and the last beat has handshaked.
- DONE_x: one cycle; sets doneX_flag; → IDLE.
- doneX_flag drives pl_status[x]. It clears when ps_control[x]==0 while the flag is set; clearing has lower priority than setting.
- A new half is not started while its flag is set.

Datapath:
- The read issued in cycle t writes bram_rddata into the FIFO at the end of cycle t+1.
- An issued read whose address is the half's last word is tagged last; the tag travels through the FIFO to m_axis_tlast.
- m_axis_tvalid = FIFO non-empty. Pop when tvalid && tready.
- tdata and tlast are stable while tvalid && !tready (AXI rule).
- Latency: ps_control bit sampled high in IDLE at cycle 0; first tvalid at cycle 3.
- With tready held at 1, throughput is one beat per cycle with no bubbles: 512 consecutive beats per half at default parameters.
- Word order is strictly ascending address. No word is dropped or duplicated under any tready pattern.
- Simultaneous FIFO push and pop in one cycle leaves the count unchanged.
- Address arithmetic is ADDR_WIDTH bits. The half-B end address 4092 is reached without wrap; the counter is reloaded, never wrapped, at the next start.

Decomposition:
- Package sigmoid_pkg:
  - Enum stream_states (the states above, 3-bit).
  - Localparams HALF_A_BASE=0 and HALF_B_BASE=HALF_BYTES.
  - Status bit indices STAT_A=0, STAT_B=1.
- One sub-module: stream_skid_fifo.
  - Parameterised width (BRAM_WIDTH+1, carrying data plus last) and depth.
  - Provides push/pop, count, and registered outputs.
- Top holds the FSM, read-address counter, credit logic, and status flags.

Test Plan:
- BRAM[i]=32'h3f000000+i; ps_control=1, tready=1 → 512 beats of 3f000000..3f0001ff; first tvalid at cycle 3; tlast only on beat 512; pl_status[0]=1 one cycle after DONE_A.
- Same fill, tready random at 30% → identical 512-word sequence, no gaps or duplicates; tdata held during stalls; bram_addr never exceeds 2044 in half A.
- ps_control=3 from IDLE → half A (addresses 0..2044) then half B (2048..4092); pl_status goes 1, then 3 (ps_control held); each tlast on its own half's final word.
- After pl_status[0]=1, hold ps_control[0]=1 → no restart; drop it to 0 → pl_status[0] clears next cycle; reassert → half A resends.
- reset=0 at beat 100 of half A for 1 cycle → tvalid 0 next cycle; pl_status 0; restart delivers from word 0.
- tready=0 for 50 cycles after the first beat → FIFO holds 4 entries, no BRAM reads issue; release → stream resumes at word 1.
